// File: rtl/lane_pkg.sv
// Shared types and helpers for the lane flush scheduler and its bench.
// lane_fill_next is the occupancy rule that both the RTL and the scoreboard use.
package lane_pkg;

    localparam int unsigned DEFAULT_CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2
    } flush_state_t;

    // The sum stays below 2*lane, so a single subtraction stands in for the modulo.
    function automatic int unsigned lane_fill_next(input int unsigned fill, input int unsigned n,
                                                   input logic flush, input int unsigned lane);
        int unsigned sum;
        sum = fill + n;
        if (flush) return 0;
        return (sum >= lane) ? sum - lane : sum;
    endfunction

endpackage

// File: rtl/lane_popcount.sv
// Combinational count of the set bits in a lane valid vector.
module lane_popcount #(
    parameter int unsigned LANE = 4
) (
    input  logic [LANE-1:0]            data_in_vd,
    output logic [$clog2(LANE+1)-1:0]  count
);

    localparam int unsigned N_W = $clog2(LANE + 1);

    always_comb begin
        count = '0;
        for (int i = 0; i < LANE; i++) begin
            count = count + N_W'(data_in_vd[i]);
        end
    end

endmodule

// File: rtl/lane_flush_scheduler.sv
// Drives the lane packer flush input: mirrors its partial-lane occupancy and pulses flush
// when residual data ages past the timeout or an external request is pending.
module lane_flush_scheduler
    import lane_pkg::*;
#(
    parameter int unsigned LANE      = 4,
    parameter int unsigned TIMEOUT_W = 16,
    parameter int unsigned CNT_W     = DEFAULT_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [LANE-1:0]           data_in_vd,
    input  logic [TIMEOUT_W-1:0]      timeout,
    input  logic                      flush_req,
    output logic                      flush,
    output logic [$clog2(LANE)-1:0]   fill,
    output logic [CNT_W-1:0]          flush_count,
    output logic [CNT_W-1:0]          timeout_flush_count
);

    localparam int unsigned FILL_W = $clog2(LANE);
    localparam int unsigned N_W    = $clog2(LANE + 1);
    localparam int unsigned SUM_W  = $clog2(2 * LANE);

    flush_state_t         state_q, state_d;
    logic [N_W-1:0]       n;
    logic [SUM_W-1:0]     sum;
    logic [FILL_W-1:0]    fill_d;
    logic                 emit;
    logic [TIMEOUT_W-1:0] age_q, age_d, age_inc;
    logic                 pend_q, pend_d;
    logic                 to_hit;
    logic                 cause_q;

    lane_popcount #(
        .LANE (LANE)
    ) u_popcount (
        .data_in_vd (data_in_vd),
        .count      (n)
    );

    always_comb begin
        sum     = SUM_W'(fill) + SUM_W'(n);
        emit    = !flush && (sum >= SUM_W'(LANE));
        fill_d  = FILL_W'(lane_fill_next(32'(fill), 32'(n), flush, LANE));
        age_inc = (&age_q) ? age_q : age_q + TIMEOUT_W'(1);
        if (fill_d == '0) begin
            age_d = '0;
        end else if ((fill == '0) || emit) begin
            // Residual elements are fresh, so their age restarts.
            age_d = TIMEOUT_W'(1);
        end else begin
            age_d = age_inc;
        end
        pend_d = flush_req || (pend_q && !flush);
        to_hit = (timeout != '0) && (age_d >= timeout) && (fill_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fill_d != '0) state_d = ACCUM;
            ACCUM:   if (fill_d == '0) state_d = IDLE;
            FLUSH:   state_d = (fill_d != '0) ? ACCUM : IDLE;
            default: state_d = IDLE;
        endcase
        if (pend_d || to_hit) state_d = FLUSH;
    end

    always_comb begin
        flush = (state_q == FLUSH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill                <= '0;
            age_q               <= '0;
            pend_q              <= 1'b0;
            cause_q             <= 1'b0;
            flush_count         <= '0;
            timeout_flush_count <= '0;
        end else begin
            fill    <= fill_d;
            age_q   <= age_d;
            pend_q  <= pend_d;
            // Remembers whether the upcoming flush is owed to the timeout alone.
            cause_q <= to_hit && !pend_d;
            if (flush) flush_count <= flush_count + CNT_W'(1);
            if (flush && cause_q) timeout_flush_count <= timeout_flush_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_lane_flush_scheduler.sv
// Directed bench for lane_flush_scheduler with LANE=4: a per-cycle vector table plus
// hand-written sequences for reset, long idle, age saturation and lowered timeout.
module tb_lane_flush_scheduler;
    import lane_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  vd;
    logic [7:0]  to;
    logic        req;
    logic        flush;
    logic [1:0]  fill;
    logic [31:0] fc;
    logic [31:0] tfc;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] vd;
        logic [7:0] to;
        logic       req;
        logic       exp_flush;
        logic [1:0] exp_fill;
        int         exp_fc;
        int         exp_tfc;
    } vec_t;

    vec_t vq[$];

    always #5 clk = ~clk;

    lane_flush_scheduler #(
        .LANE      (4),
        .TIMEOUT_W (8),
        .CNT_W     (32)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .data_in_vd          (vd),
        .timeout             (to),
        .flush_req           (req),
        .flush               (flush),
        .fill                (fill),
        .flush_count         (fc),
        .timeout_flush_count (tfc)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] v, input logic [7:0] t, input logic r,
                       input logic ef, input logic [1:0] efill, input int efc, input int etfc);
        vec_t x;
        x.vd = v; x.to = t; x.req = r;
        x.exp_flush = ef; x.exp_fill = efill; x.exp_fc = efc; x.exp_tfc = etfc;
        vq.push_back(x);
    endtask

    int nflush;
    int model_fill;

    initial begin
        // Expected outputs are those seen during the row's cycle, before its inputs are taken.
        for (int i = 0; i < 3; i++) add(4'b1111, 8'd5, 1'b0, 1'b0, 2'd0, 0, 0);
        add(4'b0011, 8'd8, 1'b0, 1'b0, 2'd0, 0, 0);
        for (int i = 0; i < 7; i++) add(4'b0000, 8'd8, 1'b0, 1'b0, 2'd2, 0, 0);
        add(4'b0000, 8'd8, 1'b0, 1'b1, 2'd2, 0, 0);
        add(4'b0000, 8'd8, 1'b0, 1'b0, 2'd0, 1, 1);
        add(4'b0111, 8'd6, 1'b0, 1'b0, 2'd0, 1, 1);
        add(4'b0011, 8'd6, 1'b0, 1'b0, 2'd3, 1, 1);
        for (int i = 0; i < 5; i++) add(4'b0000, 8'd6, 1'b0, 1'b0, 2'd1, 1, 1);
        add(4'b0000, 8'd6, 1'b0, 1'b1, 2'd1, 1, 1);
        add(4'b0000, 8'd6, 1'b0, 1'b0, 2'd0, 2, 2);
        add(4'b0000, 8'd6, 1'b1, 1'b0, 2'd0, 2, 2);
        add(4'b0000, 8'd6, 1'b1, 1'b1, 2'd0, 2, 2);
        add(4'b0000, 8'd6, 1'b0, 1'b1, 2'd0, 3, 2);
        add(4'b0000, 8'd6, 1'b0, 1'b0, 2'd0, 4, 2);
        add(4'b0001, 8'd0, 1'b1, 1'b0, 2'd0, 4, 2);
        add(4'b0010, 8'd0, 1'b0, 1'b1, 2'd1, 4, 2);
        add(4'b0000, 8'd0, 1'b0, 1'b0, 2'd0, 5, 2);
        add(4'b0001, 8'd1, 1'b0, 1'b0, 2'd0, 5, 2);
        add(4'b0000, 8'd1, 1'b0, 1'b1, 2'd1, 5, 2);
        add(4'b0000, 8'd1, 1'b0, 1'b0, 2'd0, 6, 3);
        add(4'b0001, 8'd2, 1'b0, 1'b0, 2'd0, 6, 3);
        add(4'b0000, 8'd2, 1'b1, 1'b0, 2'd1, 6, 3);
        add(4'b0000, 8'd2, 1'b0, 1'b1, 2'd1, 6, 3);
        add(4'b0000, 8'd2, 1'b0, 1'b0, 2'd0, 7, 3);

        rst_n = 1'b0; vd = '0; to = '0; req = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Build fill=3, some age and a pending request, then reset during the flush.
        @(negedge clk); vd = 4'b0111;
        @(negedge clk); vd = 4'b0000;
        repeat (4) @(negedge clk);
        check("pre_rst_fill", fill, 3);
        req = 1'b1;
        @(negedge clk); req = 1'b0;
        check("pre_rst_flush", flush, 1);
        rst_n = 1'b0;
        #1;
        check("rst_flush", flush, 0);
        check("rst_fill", fill, 0);
        check("rst_fc", fc, 0);
        check("rst_tfc", tfc, 0);
        @(negedge clk); rst_n = 1'b1;
        nflush = 0;
        repeat (5) begin
            @(negedge clk);
            if (flush) nflush++;
        end
        check("post_rst_no_flush", nflush, 0);

        foreach (vq[i]) begin
            @(negedge clk);
            check($sformatf("vec%0d_flush", i), flush, vq[i].exp_flush);
            check($sformatf("vec%0d_fill", i), fill, vq[i].exp_fill);
            check($sformatf("vec%0d_fc", i), fc, vq[i].exp_fc);
            check($sformatf("vec%0d_tfc", i), tfc, vq[i].exp_tfc);
            vd = vq[i].vd; to = vq[i].to; req = vq[i].req;
        end

        // Full lanes only: occupancy never leaves zero.
        model_fill = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("full_flush", flush, 0);
            check("full_fill", fill, model_fill);
            vd = 4'b1111; to = 8'd5; req = 1'b0;
            model_fill = lane_fill_next(model_fill, 4, 1'b0, 4);
        end

        // Timeout disabled: a single element waits indefinitely until requested.
        @(negedge clk); vd = 4'b0001; to = 8'd0;
        @(negedge clk); vd = 4'b0000;
        nflush = 0;
        repeat (1000) begin
            @(negedge clk);
            if (flush) nflush++;
        end
        check("tdis_no_flush", nflush, 0);
        check("tdis_fill", fill, 1);
        req = 1'b1;
        @(negedge clk); req = 1'b0;
        check("tdis_req_flush", flush, 1);
        @(negedge clk);
        check("tdis_fill_clear", fill, 0);
        check("tdis_single_pulse", flush, 0);

        // Age saturates at 255 rather than wrapping, so timeout=255 still fires.
        vd = 4'b0001;
        @(negedge clk); vd = 4'b0000;
        repeat (300) @(negedge clk);
        check("sat_fill", fill, 1);
        check("sat_no_flush", flush, 0);
        to = 8'hFF;
        @(negedge clk); to = 8'd0;
        check("sat_flush", flush, 1);
        @(negedge clk);
        check("sat_fill_clear", fill, 0);

        // Timeout lowered below the current age: flush on the next cycle.
        vd = 4'b0001;
        @(negedge clk); vd = 4'b0000;
        repeat (10) @(negedge clk);
        check("low_no_flush", flush, 0);
        to = 8'd3;
        @(negedge clk); to = 8'd0;
        check("low_flush", flush, 1);
        @(negedge clk);
        check("low_fill_clear", fill, 0);
        check("final_fc", fc, 10);
        check("final_tfc", tfc, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lane_flush_scheduler.md
# lane_flush_scheduler

Controller that drives the `flush` input of the `lane_packing` lane packer. It mirrors the packer's partial-lane occupancy from the same `data_in_vd` vector and pulses `flush` in two cases: partially packed data has aged past a programmable timeout, or an external request (e.g. end of a measurement window) is pending. Partial lanes therefore never stall indefinitely in the packer. It sits beside the packer in each combination datapath, in the packer's clock domain.

## Interface

Parameters:
- `LANE`, default 4, lane count of the controlled packer; must be ≥ 2.
- `TIMEOUT_W`, default 16, width of the timeout and age counter.
- `CNT_W`, default 32, width of the statistics counters.

Ports:
- `clk`  in  1  clock, shared with the packer.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `data_in_vd`  in  LANE  valid vector presented to the packer in the same cycle.
- `timeout`  in  TIMEOUT_W  age in cycles that triggers a flush; 0 disables timeout flushes. Sampled live.
- `flush_req`  in  1  external flush request, single-cycle pulse.
- `flush`  out  1  registered; connects to the packer `flush` input.
- `fill`  out  $clog2(LANE)  mirrored packer occupancy (elements currently held).
- `flush_count`  out  CNT_W  total flush pulses issued; wraps.
- `timeout_flush_count`  out  CNT_W  flush pulses caused by timeout; wraps.

## Operation

- Occupancy model, evaluated every cycle with `n = popcount(data_in_vd)`:
  - if `flush` is high: `fill_next = 0`;
  - otherwise: `fill_next = (fill + n) mod LANE`.
  - `emit = !flush && (fill + n) >= LANE`.
- Age counter, saturating at all-ones:
  - 0 when `fill_next == 0`;
  - 1 when `fill_next != 0` and (`fill == 0` or `emit`), i.e. the residual elements are new;
  - otherwise increments.
- Pending request: `flush_req` sets `pend`. `pend` clears in a cycle where `flush` is high, unless `flush_req` is high in that same cycle, in which case it stays set.
- FSM states:
  - IDLE: `fill == 0`, no pending request.
  - ACCUM: `fill != 0`, aging.
  - FLUSH: `flush` high for exactly one cycle.
- FSM transitions:
  - IDLE → ACCUM when `fill_next != 0`.
  - Any state → FLUSH when `pend_next`, or when `timeout != 0 && age_next >= timeout` with `fill_next != 0`.
  - FLUSH → IDLE or ACCUM according to `fill_next`, or back to FLUSH if a request is pending.
- Counters:
  - `flush_count` increments on every cycle with `flush` high.
  - `timeout_flush_count` increments when the flush was caused by timeout only, with no pending request.
- Data arriving in the FLUSH cycle is emitted by the packer in that same flush; the model returns to `fill = 0`.
- A flush that finds the packer empty is legal; the packer then emits `data_out_vd = 0`.

## Timing

- Reset values: `flush = 0`, `fill = 0`, age 0, `pend = 0`, state IDLE, both counters 0. Reset applies immediately on `rst_n` falling, including mid-accumulation or during FLUSH.
- The packer's own synchronous active-high reset must be derived from the same `rst_n` so that both models clear together.
- `flush_req` at cycle t → `flush` high at t+1.
- First partial element arriving at cycle t with no later data → `flush` high at cycle t+`timeout`. `timeout = 1` gives t+1.
- `fill` is registered and reflects all data up to the previous cycle.
- Simultaneous timeout and request: one flush pulse; only `flush_count` increments.
- A `flush_req` during a FLUSH cycle produces a second flush in the next cycle, so `flush` is high for two consecutive cycles.
- Age saturation: flush still fires once `timeout` is reached; no wrap.
- `timeout` lowered below the current age: flush on the next cycle.

## Structure

- Shared package `lane_pkg`:
  - FSM enum `flush_state_t` (IDLE, ACCUM, FLUSH);
  - `localparam` for the default `CNT_W`;
  - function `lane_fill_next(fill, n, flush, LANE)` for reuse by the bench scoreboard.
- Sub-module `lane_popcount` (parameter `LANE`, combinational popcount of `data_in_vd`, output `$clog2(LANE+1)` bits), instantiated once.

## Test plan

All scenarios use LANE=4.
- Reset: assert `rst_n` low with `fill = 3`, age 5, `pend = 1` → `flush = 0`, `fill = 0`, both counters 0 immediately; no flush after release.
- Full lanes only: `data_in_vd = 4'b1111` for 20 cycles, `timeout = 5` → `fill` stays 0, `flush` never high.
- Timeout flush: `4'b0011` at cycle t then zeros, `timeout = 8` → `fill = 2` from t+1, `flush` high only at t+8, `fill = 0` at t+9, `timeout_flush_count = 1`.
- Residual restart: `4'b0111` at t, `4'b0011` at t+1, `timeout = 6` → `fill` 3 then 1; age restarts at t+2; flush at t+7, not t+6.
- External request: `flush_req` at t with `fill = 0` → flush at t+1, `flush_count = 1`, `timeout_flush_count = 0`. A second `flush_req` at t+1 → flush also high at t+2, `flush_count = 2`.
- Timeout disabled: `timeout = 0`, `4'b0001` once → no flush for 1000 cycles, `fill = 1`. Then `flush_req` → flush next cycle, `fill = 0`.
